// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer: fetch-stage program counter with start/done handshake, branch LUT drive and run stats
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int PC_W       = 12,
  parameter int KEY_W      = 5,
  parameter int START_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_req,
  input  logic             br_cond,
  input  logic [KEY_W-1:0] br_key,
  output logic             branch_lut_en,
  output logic [KEY_W-1:0] key,
  input  logic [PC_W-1:0]  branch_pos,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [15:0]      cycle_cnt,
  output logic [7:0]       taken_cnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     cycle_next;
  logic [7:0]      taken_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= START_PC;
      cycle_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      cycle_cnt <= cycle_next;
      taken_cnt <= taken_next;
    end
  end

  // The LUT path is qualified so the table only sees a key when its result is consumed.
  assign branch_lut_en = (state == RUN) & br_req & br_cond & ~stall & ~halt;
  assign key           = branch_lut_en ? br_key : '0;
  assign running       = (state == RUN);
  assign done          = (state == DONE);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cycle_next = cycle_cnt;
    taken_next = taken_cnt;
    case (state)
      IDLE, DONE: begin
        if (state == IDLE) pc_next = START_PC;
        if (start) begin
          state_next = RUN;
          pc_next    = START_PC;
          cycle_next = '0;
          taken_next = '0;
        end
      end
      RUN: begin
        // Every RUN cycle counts, including stalls and the halting cycle.
        if (cycle_cnt != 16'hFFFF) cycle_next = cycle_cnt + 16'd1;
        if (halt) begin
          state_next = DONE;
        end else if (stall) begin
          pc_next = pc;
        end else if (branch_lut_en) begin
          pc_next = branch_pos;
          if (taken_cnt != 8'hFF) taken_next = taken_cnt + 8'd1;
        end else begin
          pc_next = pc + PC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_PC;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer: directed table, corner sequences and random run against a reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, stall, br_req, br_cond;
  logic [4:0]  br_key;
  logic        branch_lut_en;
  logic [4:0]  key;
  logic [11:0] branch_pos;
  logic [11:0] pc;
  logic        running, done;
  logic [15:0] cycle_cnt;
  logic [7:0]  taken_cnt;

  int checks = 0;
  int errors = 0;

  logic [11:0] lut_mem [32];

  // Reference model state: mode 0 idle, 1 run, 2 done.
  int m_mode, m_pc, m_cyc, m_tk;
  logic last_en;
  logic [4:0] last_key;

  always #5 clk = ~clk;

  assign branch_pos = lut_mem[key];

  pc_sequencer #(.PC_W(12), .KEY_W(5), .START_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
    .br_req(br_req), .br_cond(br_cond), .br_key(br_key),
    .branch_lut_en(branch_lut_en), .key(key), .branch_pos(branch_pos),
    .pc(pc), .running(running), .done(done),
    .cycle_cnt(cycle_cnt), .taken_cnt(taken_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic h, input logic st,
                        input logic rq, input logic cd, input logic [4:0] k);
    start = s; halt = h; stall = st; br_req = rq; br_cond = cd; br_key = k;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cyc = 0; m_tk = 0;
  endtask

  task automatic check_regs();
    check("pc", int'(pc), m_pc);
    check("running", int'(running), int'(m_mode == 1));
    check("done", int'(done), int'(m_mode == 2));
    check("cycle_cnt", int'(cycle_cnt), m_cyc);
    check("taken_cnt", int'(taken_cnt), m_tk);
  endtask

  // Called at posedge+1 with inputs already applied; ends at the next posedge+1.
  task automatic tick();
    logic exp_en;
    #1;
    exp_en = (m_mode == 1) && br_req && br_cond && !stall && !halt;
    check("lut_en", int'(branch_lut_en), int'(exp_en));
    check("key", int'(key), exp_en ? int'(br_key) : 0);
    last_en  = branch_lut_en;
    last_key = key;
    @(posedge clk);
    if (m_mode == 1) begin
      m_cyc = (m_cyc >= 65535) ? 65535 : m_cyc + 1;
      if (halt) m_mode = 2;
      else if (stall) ;
      else if (br_req && br_cond) begin
        m_pc = int'(lut_mem[br_key]);
        m_tk = (m_tk >= 255) ? 255 : m_tk + 1;
      end else m_pc = (m_pc + 1) % 4096;
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_cyc = 0; m_tk = 0;
    end
    #1;
    check_regs();
  endtask

  typedef struct {
    logic       s, h, st, rq, cd;
    logic [4:0] k;
    logic       en;
    int         kexp;
    int         pc_after;
    int         tk_after;
  } vec_t;

  vec_t vecs[18];

  initial begin
    for (int i = 0; i < 32; i++) lut_mem[i] = 12'((i * 37 + 5) % 4096);
    lut_mem[3] = 12'd16;
    lut_mem[4] = 12'd4095;
    lut_mem[5] = 12'd0;
    lut_mem[6] = 12'd10;
    lut_mem[7] = 12'd20;

    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 7; i++) vecs[i] = '{0, 0, 0, 0, 0, 0, 0, 0, i, 0};
    vecs[8]  = '{0, 0, 0, 1, 1, 3, 1, 3, 16, 1};
    vecs[9]  = '{0, 0, 0, 1, 1, 6, 1, 6, 10, 2};
    vecs[10] = '{0, 0, 0, 1, 0, 3, 0, 0, 11, 2};
    vecs[11] = '{0, 0, 1, 1, 1, 3, 0, 0, 11, 2};
    vecs[12] = '{0, 0, 0, 1, 1, 7, 1, 7, 20, 3};
    vecs[13] = '{1, 1, 1, 1, 1, 3, 0, 0, 20, 3};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 20, 3};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 1, 1, 4, 1, 4, 4095, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].s, vecs[i].h, vecs[i].st, vecs[i].rq, vecs[i].cd, vecs[i].k);
      tick();
      check($sformatf("tbl%0d_en", i), int'(last_en), int'(vecs[i].en));
      check($sformatf("tbl%0d_key", i), int'(last_key), vecs[i].kexp);
      check($sformatf("tbl%0d_pc", i), int'(pc), vecs[i].pc_after);
      check($sformatf("tbl%0d_tk", i), int'(taken_cnt), vecs[i].tk_after);
      if (i == 5) check("tbl_cyc5", int'(cycle_cnt), 5);
      if (i == 13) begin
        check("halt_cyc", int'(cycle_cnt), 13);
        check("halt_done", int'(done), 1);
        check("halt_running", int'(running), 0);
      end
      if (i == 15) check("restart_cyc", int'(cycle_cnt), 0);
    end

    // Asynchronous reset in the middle of RUN
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_pc", int'(pc), 0);
    check("areset_running", int'(running), 0);
    check("areset_cyc", int'(cycle_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      set_in(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
             1'($urandom), 5'($urandom));
      tick();
    end

    // Taken-branch saturation
    set_in(0, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 260; n++) begin
      set_in(0, 0, 0, 1, 1, 5'($urandom));
      tick();
    end
    check("taken_sat", int'(taken_cnt), 255);

    // Cycle counter saturation
    set_in(0, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 70000; n++) tick();
    check("cycle_sat", int'(cycle_cnt), 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the core's fetch stage; it sits directly upstream and downstream of the branch lookup table. It drives the table's enable and key from the decoded branch fields, consumes the returned 12-bit absolute target, and registers the next PC. It also owns the start/done program handshake and keeps run statistics: cycles spent in RUN and branches taken.

## Interface
Parameters:
- PC_W, 12, PC and branch-target width
- KEY_W, 5, branch LUT key width
- START_ADDR, 0, PC value loaded on reset and on every start

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin program; sampled only in IDLE or DONE
- halt  input  1  current instruction is HALT
- stall  input  1  hold PC this cycle
- br_req  input  1  current instruction is a conditional branch
- br_cond  input  1  branch condition flag; the branch is taken when it is 1
- br_key  input  KEY_W  LUT key field of the current instruction
- branch_lut_en  output  1  enable to the branch LUT, combinational
- key  output  KEY_W  key to the branch LUT, combinational
- branch_pos  input  PC_W  absolute target returned by the LUT, same cycle
- pc  output  PC_W  registered program counter
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- cycle_cnt  output  16  RUN cycles of the last or current program, saturating
- taken_cnt  output  8  taken branches of the last or current program, saturating

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state IDLE, pc=START_ADDR.
  - running=0, done=0, cycle_cnt=0, taken_cnt=0.
  - Reset takes effect immediately, including mid-run.
- IDLE:
  - pc holds START_ADDR.
  - start=1 moves to RUN; pc=START_ADDR and both counters are cleared.
- RUN, priority per cycle (highest first):
  1. halt=1: go to DONE and hold pc. A stall or branch in the same cycle is ignored.
  2. stall=1: hold pc. A branch in the same cycle is not taken and not counted.
  3. br_req & br_cond: pc <= branch_pos; taken_cnt += 1, saturating at 255.
  4. Otherwise: pc <= pc + 1, modulo 2^PC_W. 4095 wraps to 0 with no flag.
- A branch with br_req=1 and br_cond=0 is not taken: pc increments.
- LUT drive:
  - branch_lut_en = RUN & br_req & br_cond & ~stall & ~halt.
  - key = br_key when branch_lut_en=1, otherwise 0.
  - branch_pos is used only when branch_lut_en=1. A returned value of 0 is a legal target.
- cycle_cnt increments on every cycle spent in RUN, including stall cycles and the halt cycle, and saturates at 0xFFFF.
- DONE:
  - pc and both counters hold.
  - done=1.
  - start=1 re-enters RUN with pc=START_ADDR and both counters cleared.
- start is ignored while in RUN.

## Timing
- pc, state and the counters are registered.
- branch_lut_en and key are combinational from the current inputs and state. branch_pos must settle in the same cycle; the combinational path is br_key -> LUT -> pc D input.
- start sampled at edge N: running=1 and pc=START_ADDR after N. The first increment lands at edge N+1.
- Taken branch sampled at edge N: pc=branch_pos after N. There is no bubble.
- halt sampled at edge N: running=0 and done=1 after N. done stays high until start is sampled or reset.
- start and halt in the same RUN cycle: halt wins and start is ignored.
- Counters saturate; they never wrap.

## Test plan
- Reset then run: assert rst_n=0 mid-cycle with no clock, then release and pulse start with idle inputs for 5 cycles -> pc reads 0,1,2,3,4; running=1; cycle_cnt=5; done=0. Assert rst_n=0 during RUN -> pc=0, running=0 and cycle_cnt=0 immediately, asynchronously.
- Taken branch: bench LUT maps key 3 -> 16. In RUN at pc=7, drive br_req=1, br_cond=1, br_key=3 -> branch_lut_en=1 and key=3 that cycle; pc=16 next; taken_cnt=1.
- Not-taken and stalled branch:
  - br_req=1, br_cond=0 at pc=10 -> branch_lut_en=0, key=0, pc=11.
  - Same branch with cond=1 and stall=1 -> pc holds at 11 and taken_cnt is unchanged.
- Halt priority: at pc=20 drive halt=1, stall=1 and a taken branch -> pc stays 20, done=1 and running=0 next cycle, branch_lut_en=0. cycle_cnt equals the RUN cycles including the halt cycle. start then gives pc=0 and both counters cleared.
- Wrap and saturation:
  - Branch to 4095, then one increment -> pc=0.
  - 260 consecutive taken branches -> taken_cnt=255.
  - 70000 RUN cycles -> cycle_cnt=65535.
